// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jump flush, memory-miss freeze and watchdog.
// Optional macro HAZ_PERF_CNT_EN adds the Stall_Cycles / Flush_Count performance counters.
module hazard_stall_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       EX_Mem_Read,
  input  logic [4:0] EX_Rt,
  input  logic       Branch_Taken,
  input  logic       Jump,
  input  logic       Mem_Req,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       NoOp,
  output logic       IF_Flush,
  output logic       Freeze,
  output logic       Mem_Error
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Cycles,
  output logic [15:0] Flush_Count
`endif
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]    BUB_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t        state;
  logic [2:0]    bub_cnt;
  logic [WW-1:0] wait_cnt;
  logic          ret_lu;
  logic          lu;
  logic          miss;

  assign lu   = EX_Mem_Read && (EX_Rt != 5'd0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
  assign miss = Mem_Req && !Mem_Ready;

  // Outputs follow priority: rst > miss/MEM_WAIT > load-use stall > flush > normal.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    NoOp        = 1'b0;
    IF_Flush    = 1'b0;
    Freeze      = 1'b0;
    if (rst) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      NoOp        = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (miss) begin
            Freeze      = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
          end else if (lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            NoOp        = 1'b1;
          end else if (Branch_Taken || Jump) begin
            IF_Flush = 1'b1;
          end
        end
        LU_STALL: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          if (miss) Freeze = 1'b1;
          else      NoOp   = 1'b1;
        end
        MEM_WAIT: begin
          // The ready cycle releases the freeze and lets the pipeline advance.
          if (!Mem_Ready) begin
            Freeze      = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      bub_cnt   <= 3'd0;
      wait_cnt  <= '0;
      ret_lu    <= 1'b0;
      Mem_Error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
            ret_lu   <= 1'b0;
          end else if (lu && (LU_BUBBLES > 1)) begin
            state   <= LU_STALL;
            bub_cnt <= BUB_INIT;
          end
        end
        LU_STALL: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
            ret_lu   <= 1'b1;
          end else begin
            bub_cnt <= bub_cnt - 3'd1;
            if (bub_cnt <= 3'd1) state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (Mem_Ready) begin
            wait_cnt <= '0;
            state    <= (ret_lu && (bub_cnt != 3'd0)) ? LU_STALL : RUN;
          end else if (wait_cnt == WAIT_MAX) begin
            // Memory never answered: give up on the access and the pending stall.
            Mem_Error <= 1'b1;
            state     <= RUN;
            wait_cnt  <= '0;
            bub_cnt   <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Cycles <= 16'd0;
      Flush_Count  <= 16'd0;
    end else begin
      if ((NoOp || Freeze) && (Stall_Cycles != 16'hFFFF)) Stall_Cycles <= Stall_Cycles + 16'd1;
      if (IF_Flush && (Flush_Count != 16'hFFFF))          Flush_Count  <= Flush_Count + 16'd1;
    end
  end
`endif

endmodule
